// File: rtl/quad_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : quad_pkg
// Brief  : Shared phase, direction and FSM encodings for the quadrature decoder.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
package quad_pkg;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

   // Forward Gray sequence 00 -> 01 -> 11 -> 10 -> 00 counts up.
   function automatic logic phase_is_up(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
      logic up;
      up = 1'b0;
      case ({prev_ab, cur_ab})
         {PH_00, PH_01},
         {PH_01, PH_11},
         {PH_11, PH_10},
         {PH_10, PH_00}: up = 1'b1;
         default:        up = 1'b0;
      endcase
      return up;
   endfunction

endpackage
`default_nettype wire

// File: rtl/glitch_filter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : glitch_filter
// Brief  : Two-flop synchronizer plus hold-count filter for one encoder channel.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module glitch_filter #(
   parameter int FILTER_CYCLES = 16
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic load,
   input  logic raw,
   output logic synced,
   output logic level
);

   localparam int              CW          = $clog2(FILTER_CYCLES);
   localparam logic [CW-1:0]   C_HOLD_LAST = CW'(FILTER_CYCLES - 1);
   localparam logic [CW-1:0]   C_ONE       = CW'(1);

   logic          r_meta;
   logic [CW-1:0] r_hold_cnt;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_meta     <= 1'b0;
         synced     <= 1'b0;
         level      <= 1'b0;
         r_hold_cnt <= '0;
      end else begin
         r_meta <= raw;
         synced <= r_meta;
         // Accept a new level only on the FILTER_CYCLES-th consecutive mismatch.
         if (load) begin
            level      <= synced;
            r_hold_cnt <= '0;
         end else if (synced == level) begin
            r_hold_cnt <= '0;
         end else if (r_hold_cnt == C_HOLD_LAST) begin
            level      <= synced;
            r_hold_cnt <= '0;
         end else begin
            r_hold_cnt <= r_hold_cnt + C_ONE;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : quad_decoder
// Brief  : x4 quadrature decoder with glitch filtering, wrapping count, STEP/ERROR.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module quad_decoder
   import quad_pkg::*;
#(
   parameter int FILTER_CYCLES = 16,
   parameter int COUNT_WIDTH   = 4,
   parameter int INIT_CYCLES   = 3
) (
   input  logic                   CLOCK,
   input  logic                   RESET,
   input  logic                   ENC_A,
   input  logic                   ENC_B,
   output logic [COUNT_WIDTH-1:0] COUNT_OUT,
   output logic                   DIRECTION,
   output logic                   STEP,
   output logic                   ERROR
);

   localparam int                   IW          = $clog2(INIT_CYCLES);
   localparam logic [IW-1:0]        C_INIT_LAST = IW'(INIT_CYCLES - 1);
   localparam logic [IW-1:0]        C_INIT_ONE  = IW'(1);
   localparam logic [COUNT_WIDTH-1:0] C_CNT_ONE = COUNT_WIDTH'(1);

   state_t        r_state;
   logic [IW-1:0] r_init_cnt;
   logic [1:0]    r_phase;
   logic [1:0]    r_prev_ab;

   logic       w_load;
   logic       w_sync_a, w_sync_b;
   logic       w_filt_a, w_filt_b;
   logic [1:0] w_sync_ab;
   logic [1:0] w_filt_ab;
   logic [1:0] w_delta;

   assign w_load    = (r_state == ST_INIT);
   assign w_sync_ab = {w_sync_a, w_sync_b};
   assign w_filt_ab = {w_filt_a, w_filt_b};
   assign w_delta   = r_prev_ab ^ r_phase;

   glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .load   (w_load),
      .raw    (ENC_A),
      .synced (w_sync_a),
      .level  (w_filt_a)
   );

   glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .load   (w_load),
      .raw    (ENC_B),
      .synced (w_sync_b),
      .level  (w_filt_b)
   );

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
         r_phase    <= PH_00;
         r_prev_ab  <= PH_00;
         COUNT_OUT  <= '0;
         DIRECTION  <= DIR_UP;
         STEP       <= 1'b0;
         ERROR      <= 1'b0;
      end else begin
         STEP  <= 1'b0;
         ERROR <= 1'b0;
         case (r_state)
            ST_INIT: begin
               // Every pipeline stage takes the synced phase so TRACK starts with no false edge.
               r_phase   <= w_sync_ab;
               r_prev_ab <= w_sync_ab;
               if (r_init_cnt == C_INIT_LAST) begin
                  r_state <= ST_TRACK;
               end else begin
                  r_init_cnt <= r_init_cnt + C_INIT_ONE;
               end
            end
            ST_TRACK: begin
               r_phase   <= w_filt_ab;
               r_prev_ab <= r_phase;
               if (w_delta == 2'b11) begin
                  ERROR <= 1'b1;
               end else if (w_delta != 2'b00) begin
                  STEP <= 1'b1;
                  if (phase_is_up(r_prev_ab, r_phase)) begin
                     COUNT_OUT <= COUNT_OUT + C_CNT_ONE;
                     DIRECTION <= DIR_UP;
                  end else begin
                     COUNT_OUT <= COUNT_OUT - C_CNT_ONE;
                     DIRECTION <= DIR_DOWN;
                  end
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_quad_decoder
// Brief  : Scoreboard bench for quad_decoder (FILTER_CYCLES=4, INIT_CYCLES=3, COUNT_WIDTH=4).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_quad_decoder;

   localparam int C_LATENCY = 8;   // drive-time cycle to observed pulse: FILTER_CYCLES+3 edges, plus one
   localparam int C_HOLD    = 10;

   logic       CLOCK;
   logic       RESET;
   logic       ENC_A;
   logic       ENC_B;
   logic [3:0] COUNT_OUT;
   logic       DIRECTION;
   logic       STEP;
   logic       ERROR;

   typedef struct {
      bit is_err;
      int count;
      bit dir;
      int due;
   } exp_t;

   exp_t       q[$];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_errors = 0;
   int         m_count;
   bit         m_dir;
   logic [1:0] cur_ab;

   quad_decoder #(
      .FILTER_CYCLES (4),
      .COUNT_WIDTH   (4),
      .INIT_CYCLES   (3)
   ) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .ENC_A     (ENC_A),
      .ENC_B     (ENC_B),
      .COUNT_OUT (COUNT_OUT),
      .DIRECTION (DIRECTION),
      .STEP      (STEP),
      .ERROR     (ERROR)
   );

   initial begin
      CLOCK = 1'b0;
      forever #5 CLOCK = ~CLOCK;
   end

   always @(posedge CLOCK) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit model_up(input logic [1:0] p, input logic [1:0] c);
      logic [3:0] pc;
      pc = {p, c};
      return (pc == 4'b0001) || (pc == 4'b0111) || (pc == 4'b1110) || (pc == 4'b1000);
   endfunction

   // Scoreboard consumer: every pulse must match the oldest pending expectation.
   always @(negedge CLOCK) begin
      if (!RESET) begin
         if (STEP || ERROR) begin
            check_eq("step_error_exclusive", int'(STEP & ERROR), 0);
            if (q.size() == 0) begin
               check_eq("unexpected_pulse", int'({STEP, ERROR}), 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check_eq("pulse_kind_error", int'(ERROR), int'(e.is_err));
               check_eq("count", int'(COUNT_OUT), e.count);
               check_eq("direction", int'(DIRECTION), int'(e.dir));
               check_eq("latency", cyc, e.due);
            end
         end else if (q.size() > 0 && cyc > q[0].due) begin
            check_eq("missing_pulse", int'(STEP | ERROR), 1);
            void'(q.pop_front());
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_count"}, int'(COUNT_OUT), 0);
      check_eq({tag, "_dir"},   int'(DIRECTION), 1);
      check_eq({tag, "_step"},  int'(STEP), 0);
      check_eq({tag, "_error"}, int'(ERROR), 0);
   endtask

   task automatic do_reset(input logic [1:0] ab, input string tag);
      @(negedge CLOCK);
      q.delete();
      RESET = 1'b1;
      ENC_A = ab[1];
      ENC_B = ab[0];
      cur_ab  = ab;
      m_count = 0;
      m_dir   = 1'b1;
      #1;
      check_reset_outputs(tag);
      repeat (3) @(negedge CLOCK);
      RESET = 1'b0;
      repeat (20) @(negedge CLOCK);
   endtask

   task automatic drive_phase(input logic [1:0] ab);
      logic [1:0] d;
      d = cur_ab ^ ab;
      @(negedge CLOCK);
      ENC_A = ab[1];
      ENC_B = ab[0];
      if (d == 2'b11) begin
         q.push_back('{1'b1, m_count, m_dir, cyc + C_LATENCY});
      end else if (d != 2'b00) begin
         if (model_up(cur_ab, ab)) begin
            m_count = (m_count + 1) % 16;
            m_dir   = 1'b1;
         end else begin
            m_count = (m_count + 15) % 16;
            m_dir   = 1'b0;
         end
         q.push_back('{1'b0, m_count, m_dir, cyc + C_LATENCY});
      end
      cur_ab = ab;
      repeat (C_HOLD - 1) @(negedge CLOCK);
   endtask

   initial begin
      RESET = 1'b1;
      ENC_A = 1'b0;
      ENC_B = 1'b0;
      do_reset(2'b00, "reset0");

      // Four up steps around the Gray cycle.
      drive_phase(2'b01);
      drive_phase(2'b11);
      drive_phase(2'b10);
      drive_phase(2'b00);
      repeat (10) @(negedge CLOCK);
      check_eq("up4_count", int'(COUNT_OUT), 4);
      check_eq("up4_dir", int'(DIRECTION), 1);

      // Down from zero wraps to all-ones, then back up wraps to zero.
      do_reset(2'b00, "reset1");
      drive_phase(2'b10);
      repeat (10) @(negedge CLOCK);
      check_eq("down_wrap_count", int'(COUNT_OUT), 15);
      check_eq("down_wrap_dir", int'(DIRECTION), 0);
      drive_phase(2'b00);
      repeat (10) @(negedge CLOCK);
      check_eq("up_wrap_count", int'(COUNT_OUT), 0);

      // Three-cycle glitch on A must be absorbed.
      @(negedge CLOCK);
      ENC_A = 1'b1;
      repeat (3) @(negedge CLOCK);
      ENC_A = 1'b0;
      repeat (20) @(negedge CLOCK);
      check_eq("glitch_count", int'(COUNT_OUT), 0);

      // Double change gives ERROR, then tracking resumes from the new phase.
      drive_phase(2'b11);
      repeat (10) @(negedge CLOCK);
      check_eq("error_count", int'(COUNT_OUT), 0);
      drive_phase(2'b10);
      repeat (10) @(negedge CLOCK);
      check_eq("after_error_count", int'(COUNT_OUT), 1);

      // Inputs at 11 across reset release: INIT must not emit anything.
      do_reset(2'b11, "reset2");
      check_eq("init11_count", int'(COUNT_OUT), 0);
      drive_phase(2'b10);
      repeat (10) @(negedge CLOCK);
      check_eq("init11_step_count", int'(COUNT_OUT), 1);

      drive_phase(2'b00);
      drive_phase(2'b01);
      drive_phase(2'b11);
      drive_phase(2'b10);
      repeat (10) @(negedge CLOCK);
      check_eq("pre_reset_count", int'(COUNT_OUT), 5);

      // Reset two cycles after a raw edge: the pending step is discarded.
      @(negedge CLOCK);
      ENC_A = 1'b0;
      ENC_B = 1'b0;
      repeat (2) @(negedge CLOCK);
      #2;
      q.delete();
      RESET = 1'b1;
      #1;
      check_reset_outputs("midreset");
      cur_ab  = 2'b00;
      m_count = 0;
      m_dir   = 1'b1;
      repeat (3) @(negedge CLOCK);
      RESET = 1'b0;
      repeat (30) @(negedge CLOCK);
      check_eq("midreset_after_count", int'(COUNT_OUT), 0);
      check_eq("midreset_after_dir", int'(DIRECTION), 1);

      repeat (5) @(negedge CLOCK);
      check_eq("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
